// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and a variable-latency memory.
// The controller holds req with stable address/data until the memory returns a one-cycle ack.
interface dmem_access_ctrl_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: IDLE -> BUSY (req held until ack or timeout) -> DONE.
// Builds byte enables / replicated store data and extends load data; stalls the pipeline while busy.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [1:0]            mem_width_i,
  input  logic                  mem_sign_extend_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  dmem_access_ctrl_if.master    dmem,
  output logic [31:0]           load_data_o,
  output logic                  stall_o,
  output logic                  mem_wb_bubble_o,
  output logic                  misalign_o,
  output logic                  timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_off;
  logic [1:0]  r_width;
  logic        r_sign;
  logic [31:0] r_load_data;
  logic        r_timeout;

  logic        w_access;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  function automatic logic [31:0] f_extract(input logic [1:0] width, input logic sign,
                                            input logic [1:0] off, input logic [31:0] rdata);
    logic        [31:0] s;
    logic signed [31:0] r;
    s = rdata >> {off, 3'b000};
    case (width)
      2'b00:   r = sign ? 32'(signed'(s[7:0]))  : {24'b0, s[7:0]};
      2'b01:   r = sign ? 32'(signed'(s[15:0])) : {16'b0, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  assign w_access   = mem_read_i | mem_write_i;
  assign w_misalign = (r_state == S_IDLE) & w_access &
                      ((mem_width_i == 2'b01 & addr_i[0]) |
                       (mem_width_i == 2'b10 & (addr_i[1:0] != 2'b00)) |
                       (mem_width_i == 2'b11));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_i;
    case (mem_width_i)
      2'b00: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << addr_i[1:0];
        w_wdata = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Stall is gated by rst_n so it falls with the asynchronous reset even if EX/MEM still holds an access.
  always_comb begin
    stall_o = 1'b0;
    case (r_state)
      S_IDLE:  stall_o = w_access & ~w_misalign;
      S_BUSY:  stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
    stall_o = stall_o & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_be        <= 4'd0;
      r_wdata     <= 32'd0;
      r_off       <= 2'd0;
      r_width     <= 2'd0;
      r_sign      <= 1'b0;
      r_load_data <= 32'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access && !w_misalign) begin
            r_req   <= 1'b1;
            r_we    <= mem_write_i;
            r_addr  <= {addr_i[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_off   <= addr_i[1:0];
            r_width <= mem_width_i;
            r_sign  <= mem_sign_extend_i;
            r_cnt   <= 8'd0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          // Ack has priority over an expiring counter in the same cycle.
          if (dmem.dmem_ack_i) begin
            r_load_data <= r_we ? 32'd0 : f_extract(r_width, r_sign, r_off, dmem.dmem_rdata_i);
            r_req       <= 1'b0;
            r_state     <= S_DONE;
          end else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            r_load_data <= 32'd0;
            r_req       <= 1'b0;
            r_timeout   <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req_o   = r_req;
  assign dmem.dmem_we_o    = r_we;
  assign dmem.dmem_addr_o  = r_addr;
  assign dmem.dmem_be_o    = r_be;
  assign dmem.dmem_wdata_o = r_wdata;
  assign load_data_o       = r_load_data;
  assign mem_wb_bubble_o   = stall_o;
  assign misalign_o        = w_misalign;
  assign timeout_o         = r_timeout;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences the MEM-stage data-memory access for the 5-stage RISC-V pipeline.
- Takes load/store control and address/data from the EX/MEM pipeline register and drives a variable-latency data memory over a req/ack handshake.
- Generates byte enables and store-data lane replication; extracts and sign/zero-extends load data.
- Raises a pipeline stall while an access is in flight and tells MEM/WB to take a bubble.

Parameters:
TIMEOUT_CYCLES, 255, max BUSY cycles waiting for dmem_ack_i before abort (1..255)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_read_i  input  1  load in EX/MEM
mem_write_i  input  1  store in EX/MEM
mem_width_i  input  2  00 byte, 01 half, 10 word, 11 reserved
mem_sign_extend_i  input  1  1 = sign-extend load result
addr_i  input  32  ALU result (effective address)
wdata_i  input  32  store data (reg 2)
dmem_req_o  output  1  memory request, held until ack
dmem_we_o  output  1  1 = write
dmem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
dmem_be_o  output  4  byte enables
dmem_wdata_o  output  32  lane-replicated store data
dmem_ack_i  input  1  memory completion, one-cycle pulse
dmem_rdata_i  input  32  read data, valid with ack
load_data_o  output  32  extended load result, valid in DONE
stall_o  output  1  hold PC, IF/ID, ID/EX, EX/MEM
mem_wb_bubble_o  output  1  MEM/WB loads a bubble (equals stall_o)
misalign_o  output  1  combinational misalignment flag
timeout_o  output  1  one-cycle pulse on access abort

Behaviour:
Reset:
- State = IDLE.
- dmem_req_o, dmem_we_o, timeout_o = 0.
- dmem_addr_o, dmem_be_o, dmem_wdata_o, load_data_o = 0.
- Timeout counter = 0.
- Reset is asynchronous: asserting rst_n low mid-BUSY drops dmem_req_o immediately. An ack arriving afterwards is ignored.

Misalignment (combinational, IDLE only):
- misalign_o = access & (half & addr[0] | word & addr[1:0]!=0 | width==11).
- access = mem_read_i | mem_write_i.
- A misaligned access is dropped: no request, no stall, pipeline advances.

States:
- IDLE:
  - stall_o = access & ~misalign_o.
  - On an aligned access, at the clock edge: latch dmem_we_o=mem_write_i, dmem_addr_o, dmem_be_o, dmem_wdata_o; set dmem_req_o<=1; clear counter; go to BUSY.
  - dmem_ack_i is ignored.
- BUSY:
  - stall_o=1; dmem_req_o held 1 with address, data and enables stable.
  - Counter increments each cycle.
  - On dmem_ack_i=1: load_data_o <= extracted rdata (stores: load_data_o <= 0); dmem_req_o<=0; go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: dmem_req_o<=0; timeout_o<=1 for one cycle; load_data_o<=0; go to DONE.
  - Ack and timeout in the same cycle: ack wins, timeout_o stays 0.
- DONE:
  - stall_o=0; the pipeline advances at the end of this cycle.
  - access inputs are ignored (the same instruction is still in EX/MEM), so there is no re-issue.
  - Next state is IDLE; load_data_o holds until the next completion.

Latency:
- Accept cycle in IDLE plus N BUSY cycles, where ack arrives in the Nth BUSY cycle, plus 1 DONE cycle.
- Minimum is 3 cycles with ack in the first BUSY cycle.

Byte enables and write data:
- Byte: be = 0001<<addr[1:0]; wdata = {4{wdata_i[7:0]}}.
- Half: be = 0011<<addr[1:0]; wdata = {2{wdata_i[15:0]}}.
- Word: be = 1111; wdata = wdata_i.
- Loads latch be the same way; dmem_we_o=0.

Load extract:
- Shift rdata right by 8*addr[1:0] using the latched offset.
- Byte: bits [7:0], extended from bit 7 if sign, else zero.
- Half: bits [15:0], extended from bit 15 if sign, else zero.
- Word: unchanged.
- mem_read_i and mem_write_i both high: treated as a store.

Test Plan:
- SW 0xDEADBEEF @0x100, ack on 3rd BUSY cycle → req high exactly 3 cycles; we=1, be=1111, addr 0x100; stall high 4 cycles, then low 1 DONE cycle.
- LB signed @0x103, rdata 0x80FF0000, ack first BUSY cycle → be=1000, load_data_o=0xFFFFFF80. Repeat LBU → 0x00000080. Stall high exactly 2 cycles.
- SH 0x00001234 @0x102 → be=1100, wdata=0x12341234. LH signed @0x102 with rdata 0x8001xxxx → 0xFFFF8001.
- LW @0x102 → misalign_o=1, req never rises, stall_o=0. Width=11 @0x100 → misalign_o=1.
- TIMEOUT_CYCLES=4, no ack → req high 4 cycles; timeout_o single pulse entering DONE; load_data_o=0. Rerun with ack in the 4th cycle → timeout_o=0, data captured.
- rst_n low in 2nd BUSY cycle → req/stall drop asynchronously, state IDLE. Ack pulse after reset release is ignored; next access proceeds normally.
